seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Monitor that sits on the multiplexed 7‑segment outputs of the vending machine display path and reconstructs the eight displayed digits. It samples `bit_select`/`seg_select`, filters scan transitions and ghosting, decodes each segment pattern back to a hex nibble, and publishes a complete frame once every digit position has been seen. It is used for on‑board self‑check and as the bench's scoreboard front end for amount displays (need, input and change money).

## Interface
- `SETTLE`, 4: consecutive identical samples required before a digit is accepted (≥2).
- `TIMEOUT`, 1_000_000: cycles without any accepted digit before `stalled` asserts (≤2^20).
- `sys_clk` in 1: system clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `bit_select` in 8: digit enables, active-low, one-hot; bit *k* selects digit *k*.
- `seg_select` in 8: segments, active-low, bits {dp,g,f,e,d,c,b,a} = [7:0].
- `err_clr` in 1: one-cycle pulse that clears the sticky error flags.
- `digits` out 32: decoded nibbles; digit *k* occupies [4k+3:4k].
- `blank` out 8: bit *k* = 1 if digit *k* was dark.
- `dp` out 8: bit *k* = decimal point state of digit *k*.
- `frame_valid` out 1: one-cycle pulse when `digits`/`blank`/`dp` update.
- `frame_count` out 8: count of frames published, wraps 255→0.
- `err_onehot` out 1: sticky; a stable `bit_select` was neither all-ones nor one-hot-low.
- `err_glyph` out 1: sticky; a stable, selected segment pattern matched no glyph.
- `stalled` out 1: no digit accepted for `TIMEOUT` cycles.

## Operation
- Reset: all outputs 0; shadow registers, seen mask, counters cleared; FSM to WAIT.
- Sample register holds the previous {bit,seg}. A stability counter resets to 1 on change and otherwise increments, saturating at `SETTLE`.
- FSM states: WAIT (input changing, count < `SETTLE`) → STABLE (count reached `SETTLE`; evaluate once) → HOLD (already evaluated; stay until the input changes) → WAIT.
- Evaluation in STABLE: invert both buses. If `bit_select` is all-off, nothing is captured. If it is not one-hot, set `err_onehot` and capture nothing. Otherwise digit *k* is captured.
- Glyph map on {g..a}, after inversion: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Pattern 00 is blank: nibble 0, blank=1. Any other unmatched pattern sets `err_glyph`, and the digit is captured as nibble 0, blank=0. The dp bit is captured independently.
- Each capture writes the shadow nibble, blank and dp for digit *k*, sets seen[*k*], and clears the stall counter.
- When seen becomes 8'hFF: load the outputs from the shadow, including the digit captured in this same cycle. Then pulse `frame_valid`, increment `frame_count` and clear seen.
- Repeated captures of one digit before the frame completes overwrite its shadow entry. The last value wins.
- `err_clr` clears both sticky flags. If an error is detected in the same cycle, the error wins and the flag stays 1.
- Stall counter increments each cycle without a capture and saturates. `stalled` = (counter ≥ `TIMEOUT`). It drops on the edge of the next capture.
- Asynchronous reset mid-frame discards partial shadow and seen state. The next frame requires all eight digits again.

## Timing
- The capture edge is the `SETTLE`-th consecutive identical sample. Shadow and seen update at that edge.
- On a frame-completing capture, `digits`/`blank`/`dp`/`frame_count` update at that same edge. `frame_valid` is high for exactly the following cycle.
- Error flags rise on the evaluation edge.
- `stalled` rises `TIMEOUT` cycles after the last capture edge.
- Dwell shorter than `SETTLE` cycles is ignored entirely (ghost filter).
- Inputs are in the `sys_clk` domain; no synchronizer.

## Test plan
- `SETTLE`=4: scan digits 0..7 with glyphs "12345678" at 10 cycles each → a single `frame_valid`; `digits`=32'h87654321; blank=0; `frame_count`=1.
- Digit 3 shows blank (seg=8'hFF) with dp lit on digit 0 (seg[7]=0) → blank=8'h08, dp=8'h01, digits[15:12]=0.
- Insert 2‑cycle glitches (bit=8'hFC; then a valid select with glyph 8'h00) between digits → no capture and no error. A 5‑cycle hold of bit=8'hFC → `err_onehot`=1. An `err_clr` pulse → 0.
- Pattern g..a=7'h2A on digit 5 → `err_glyph`=1; digit 5 reported as nibble 0, blank=0.
- `TIMEOUT`=64: stop scanning (bit=8'hFF) → `stalled`=1 at cycle 64 after the last capture; resuming a scan clears it on the first capture.
- Assert reset after 5 digits, release, then scan 8 digits → exactly one `frame_valid`, after the 8th post-reset digit, with `frame_count`=1.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: watches the multiplexed 7-segment drive of the display
// and rebuilds the eight shown digits. A digit is accepted only after its
// select/segment pair has held steady long enough to reject scan ghosts.
// Once all eight positions have been seen, the frame is published.
module seg_scan_decoder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  bit_select,
  input  logic [7:0]  seg_select,
  input  logic        err_clr,
  output logic [31:0] digits,
  output logic [7:0]  blank,
  output logic [7:0]  dp,
  output logic        frame_valid,
  output logic [7:0]  frame_count,
  output logic        err_onehot,
  output logic        err_glyph,
  output logic        stalled
);

  localparam int CNT_W   = $clog2(SETTLE + 1);
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   SETTLE_V  = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [STALL_W-1:0] TIMEOUT_V = STALL_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_STABLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t               r_state;
  logic [15:0]          r_sample;
  logic [CNT_W-1:0]     r_stableCnt;
  logic [31:0]          r_shDigits;
  logic [7:0]           r_shBlank;
  logic [7:0]           r_shDp;
  logic [7:0]           r_seen;
  logic [31:0]          r_digits;
  logic [7:0]           r_blank;
  logic [7:0]           r_dp;
  logic                 r_frameValid;
  logic [7:0]           r_frameCount;
  logic                 r_errOnehot;
  logic                 r_errGlyph;
  logic [STALL_W-1:0]   r_stallCnt;

  logic [15:0]          w_bus;
  logic                 w_changed;
  logic [CNT_W-1:0]     w_cntNext;
  logic                 w_eval;
  logic [7:0]           w_selInv;
  logic [7:0]           w_segInv;
  logic                 w_selNone;
  logic                 w_selOneHot;
  logic [2:0]           w_digitIdx;
  logic [3:0]           w_glyphNib;
  logic                 w_glyphHit;
  logic                 w_glyphBlank;
  logic                 w_capture;
  logic                 w_setErrOnehot;
  logic                 w_setErrGlyph;
  logic [31:0]          w_shDigitsNext;
  logic [7:0]           w_shBlankNext;
  logic [7:0]           w_shDpNext;
  logic [7:0]           w_seenNext;
  logic                 w_frameDone;

  assign w_bus    = {bit_select, seg_select};
  assign w_selInv = ~bit_select;
  assign w_segInv = ~seg_select;

  // Stability counter: restarts at one on any input change, saturates at SETTLE
  always_comb begin
    w_changed = (w_bus != r_sample);
    if (w_changed) begin
      w_cntNext = CNT_ONE;
    end else if (r_stableCnt >= SETTLE_V) begin
      w_cntNext = SETTLE_V;
    end else begin
      w_cntNext = r_stableCnt + CNT_ONE;
    end
    w_eval = (r_state == S_WAIT) && !w_changed && (w_cntNext == SETTLE_V);
  end

  // Classify the active-low select bus and locate the selected digit
  always_comb begin
    w_selNone   = (w_selInv == 8'h00);
    w_selOneHot = !w_selNone && ((w_selInv & (w_selInv - 8'd1)) == 8'h00);
    w_digitIdx  = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (w_selInv[k]) begin
        w_digitIdx = 3'(k);
      end
    end
  end

  // Map the lit segments g..a back to a hex nibble; all-dark is a blank digit
  always_comb begin
    w_glyphNib   = 4'h0;
    w_glyphHit   = 1'b1;
    w_glyphBlank = 1'b0;
    case (w_segInv[6:0])
      7'h3F: w_glyphNib = 4'h0;
      7'h06: w_glyphNib = 4'h1;
      7'h5B: w_glyphNib = 4'h2;
      7'h4F: w_glyphNib = 4'h3;
      7'h66: w_glyphNib = 4'h4;
      7'h6D: w_glyphNib = 4'h5;
      7'h7D: w_glyphNib = 4'h6;
      7'h07: w_glyphNib = 4'h7;
      7'h7F: w_glyphNib = 4'h8;
      7'h6F: w_glyphNib = 4'h9;
      7'h77: w_glyphNib = 4'hA;
      7'h7C: w_glyphNib = 4'hB;
      7'h39: w_glyphNib = 4'hC;
      7'h5E: w_glyphNib = 4'hD;
      7'h79: w_glyphNib = 4'hE;
      7'h71: w_glyphNib = 4'hF;
      7'h00: begin
        w_glyphHit   = 1'b0;
        w_glyphBlank = 1'b1;
      end
      default: w_glyphHit = 1'b0;
    endcase
  end

  // Merge this cycle's capture into the shadow frame and detect completion
  always_comb begin
    w_capture      = w_eval && w_selOneHot;
    w_setErrOnehot = w_eval && !w_selNone && !w_selOneHot;
    w_setErrGlyph  = w_capture && !w_glyphHit && !w_glyphBlank;
    w_shDigitsNext = r_shDigits;
    w_shBlankNext  = r_shBlank;
    w_shDpNext     = r_shDp;
    w_seenNext     = r_seen;
    if (w_capture) begin
      w_shDigitsNext[{w_digitIdx, 2'b00} +: 4] = w_glyphNib;
      w_shBlankNext[w_digitIdx]                = w_glyphBlank;
      w_shDpNext[w_digitIdx]                   = w_segInv[7];
      w_seenNext[w_digitIdx]                   = 1'b1;
    end
    w_frameDone = w_capture && (w_seenNext == 8'hFF);
  end

  // Input sampler and scan FSM: wait for settling, evaluate once, hold until change
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sample    <= 16'h0000;
      r_stableCnt <= '0;
      r_state     <= S_WAIT;
    end else begin
      r_sample    <= w_bus;
      r_stableCnt <= w_cntNext;
      if (w_changed) begin
        r_state <= S_WAIT;
      end else begin
        case (r_state)
          S_WAIT:   if (w_eval) r_state <= S_STABLE;
          S_STABLE: r_state <= S_HOLD;
          S_HOLD:   r_state <= S_HOLD;
          default:  r_state <= S_WAIT;
        endcase
      end
    end
  end

  // Shadow frame and seen mask; the mask restarts once a frame is published
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_shDigits <= 32'h0;
      r_shBlank  <= 8'h00;
      r_shDp     <= 8'h00;
      r_seen     <= 8'h00;
    end else begin
      r_shDigits <= w_shDigitsNext;
      r_shBlank  <= w_shBlankNext;
      r_shDp     <= w_shDpNext;
      r_seen     <= w_frameDone ? 8'h00 : w_seenNext;
    end
  end

  // Published frame registers and the one-cycle frame_valid strobe
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_digits     <= 32'h0;
      r_blank      <= 8'h00;
      r_dp         <= 8'h00;
      r_frameCount <= 8'h00;
      r_frameValid <= 1'b0;
    end else begin
      r_frameValid <= w_frameDone;
      if (w_frameDone) begin
        r_digits     <= w_shDigitsNext;
        r_blank      <= w_shBlankNext;
        r_dp         <= w_shDpNext;
        r_frameCount <= r_frameCount + 8'd1;
      end
    end
  end

  // Sticky error flags; a fresh detection beats a simultaneous clear
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_errOnehot <= 1'b0;
      r_errGlyph  <= 1'b0;
    end else begin
      if (w_setErrOnehot) begin
        r_errOnehot <= 1'b1;
      end else if (err_clr) begin
        r_errOnehot <= 1'b0;
      end
      if (w_setErrGlyph) begin
        r_errGlyph <= 1'b1;
      end else if (err_clr) begin
        r_errGlyph <= 1'b0;
      end
    end
  end

  // Cycles since the last accepted digit, saturating at the stall threshold
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_stallCnt <= '0;
    end else if (w_capture) begin
      r_stallCnt <= '0;
    end else if (r_stallCnt < TIMEOUT_V) begin
      r_stallCnt <= r_stallCnt + 1'b1;
    end
  end

  assign digits      = r_digits;
  assign blank       = r_blank;
  assign dp          = r_dp;
  assign frame_valid = r_frameValid;
  assign frame_count = r_frameCount;
  assign err_onehot  = r_errOnehot;
  assign err_glyph   = r_errGlyph;
  assign stalled     = (r_stallCnt >= TIMEOUT_V);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder: directed scan sequences, a per-cycle
// reference model derived from the display rules, and literal checks.
module tb_seg_scan_decoder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 64;

  logic        sys_clk    = 1'b0;
  logic        sys_rst_n  = 1'b1;
  logic [7:0]  bit_select = 8'hFF;
  logic [7:0]  seg_select = 8'hFF;
  logic        err_clr    = 1'b0;
  logic [31:0] digits;
  logic [7:0]  blank;
  logic [7:0]  dp;
  logic        frame_valid;
  logic [7:0]  frame_count;
  logic        err_onehot;
  logic        err_glyph;
  logic        stalled;

  int testsRun    = 0;
  int testsFailed = 0;
  int fvPulses    = 0;
  int fvBase      = 0;

  seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .bit_select (bit_select),
    .seg_select (seg_select),
    .err_clr    (err_clr),
    .digits     (digits),
    .blank      (blank),
    .dp         (dp),
    .frame_valid(frame_valid),
    .frame_count(frame_count),
    .err_onehot (err_onehot),
    .err_glyph  (err_glyph),
    .stalled    (stalled)
  );

  // Free-running 100 MHz-style clock
  always #5 sys_clk = ~sys_clk;

  function automatic logic [6:0] glyphOf(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    return g;
  endfunction

  function automatic logic [7:0] segFor(input logic [3:0] n, input logic dpOn);
    return ~{dpOn, glyphOf(n)};
  endfunction

  function automatic logic [7:0] selFor(input int k);
    logic [7:0] one;
    one = 8'h01 << k;
    return ~one;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model state
  logic [3:0]  shNib   [8];
  logic        shBlank [8];
  logic        shDp    [8];
  logic [7:0]  mSeen       = 8'h00;
  logic [31:0] expDigits   = 32'h0;
  logic [7:0]  expBlank    = 8'h00;
  logic [7:0]  expDp       = 8'h00;
  logic        expFv       = 1'b0;
  logic [7:0]  expFc       = 8'h00;
  logic        expErrOh    = 1'b0;
  logic        expErrGl    = 1'b0;
  logic        expStalled  = 1'b0;
  longint      cycleNum    = 0;
  longint      lastCap     = 0;
  int          runLen      = 0;
  logic        havePrev    = 1'b0;
  logic [15:0] prevBus     = 16'h0;
  logic [15:0] mBus;
  logic [7:0]  mSel;
  logic [7:0]  mPat;
  logic [3:0]  mNib;
  logic        mFound;
  logic        mIsBlank;
  logic        detOh;
  logic        detGl;
  int          mK;

  // Model: a digit is accepted on the SETTLE-th identical sample of its bus value
  initial begin
    for (int i = 0; i < 8; i++) begin
      shNib[i] = 4'h0; shBlank[i] = 1'b0; shDp[i] = 1'b0;
    end
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        for (int i = 0; i < 8; i++) begin
          shNib[i] = 4'h0; shBlank[i] = 1'b0; shDp[i] = 1'b0;
        end
        mSeen = 8'h00; expDigits = 32'h0; expBlank = 8'h00; expDp = 8'h00;
        expFv = 1'b0; expFc = 8'h00; expErrOh = 1'b0; expErrGl = 1'b0;
        expStalled = 1'b0; lastCap = cycleNum; runLen = 0; havePrev = 1'b0;
      end else begin
        cycleNum++;
        mBus = {bit_select, seg_select};
        if (havePrev && mBus == prevBus) runLen++;
        else runLen = 1;
        prevBus = mBus; havePrev = 1'b1;
        expFv = 1'b0; detOh = 1'b0; detGl = 1'b0;
        if (runLen == SETTLE) begin
          mSel = ~bit_select;
          if ($countones(mSel) > 1) begin
            detOh = 1'b1;
          end else if ($countones(mSel) == 1) begin
            mK = 0;
            for (int i = 0; i < 8; i++) if (mSel[i]) mK = i;
            mPat = ~seg_select;
            mFound = 1'b0; mNib = 4'h0;
            for (int n = 0; n < 16; n++) begin
              if (glyphOf(4'(n)) == mPat[6:0]) begin
                mFound = 1'b1; mNib = 4'(n);
              end
            end
            mIsBlank = (mPat[6:0] == 7'h00);
            if (!mFound && !mIsBlank) detGl = 1'b1;
            shNib[mK] = mNib; shBlank[mK] = mIsBlank; shDp[mK] = mPat[7];
            mSeen[mK] = 1'b1;
            lastCap = cycleNum;
            if (mSeen == 8'hFF) begin
              for (int i = 0; i < 8; i++) begin
                expDigits[4*i +: 4] = shNib[i];
                expBlank[i] = shBlank[i];
                expDp[i] = shDp[i];
              end
              expFc = expFc + 8'd1;
              expFv = 1'b1;
              mSeen = 8'h00;
            end
          end
        end
        expErrOh = detOh ? 1'b1 : (err_clr ? 1'b0 : expErrOh);
        expErrGl = detGl ? 1'b1 : (err_clr ? 1'b0 : expErrGl);
        expStalled = ((cycleNum - lastCap) >= TIMEOUT);
      end
    end
  end

  // Compare every DUT output against the model on each falling edge
  initial begin
    forever begin
      @(negedge sys_clk);
      if (frame_valid === 1'b1) fvPulses++;
      checkOutput("digits",      digits,              expDigits);
      checkOutput("blank",       {24'h0, blank},      {24'h0, expBlank});
      checkOutput("dp",          {24'h0, dp},         {24'h0, expDp});
      checkOutput("frame_valid", {31'h0, frame_valid}, {31'h0, expFv});
      checkOutput("frame_count", {24'h0, frame_count}, {24'h0, expFc});
      checkOutput("err_onehot",  {31'h0, err_onehot}, {31'h0, expErrOh});
      checkOutput("err_glyph",   {31'h0, err_glyph},  {31'h0, expErrGl});
      checkOutput("stalled",     {31'h0, stalled},    {31'h0, expStalled});
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input logic [7:0] s, input int n);
    bit_select = b;
    seg_select = s;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic scanDigit(input int k, input logic [3:0] nib, input logic dpOn, input int n);
    applyStimulus(selFor(k), segFor(nib, dpOn), n);
  endtask

  task automatic pulseClear();
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
  endtask

  logic [3:0] frame2Nibs [8];

  initial begin
    #1 sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    checkOutput("rst_digits",      digits,               32'h0);
    checkOutput("rst_blank",       {24'h0, blank},       32'h0);
    checkOutput("rst_dp",          {24'h0, dp},          32'h0);
    checkOutput("rst_frame_valid", {31'h0, frame_valid}, 32'h0);
    checkOutput("rst_frame_count", {24'h0, frame_count}, 32'h0);
    checkOutput("rst_err_onehot",  {31'h0, err_onehot},  32'h0);
    checkOutput("rst_err_glyph",   {31'h0, err_glyph},   32'h0);
    checkOutput("rst_stalled",     {31'h0, stalled},     32'h0);
    sys_rst_n = 1'b1;

    // Frame 1: "12345678" on digits 0..7
    fvBase = fvPulses;
    for (int k = 0; k < 8; k++) scanDigit(k, 4'(k + 1), 1'b0, 10);
    applyStimulus(8'hFF, 8'hFF, 2);
    checkOutput("f1_digits",   digits,               32'h87654321);
    checkOutput("f1_blank",    {24'h0, blank},       32'h0);
    checkOutput("f1_dp",       {24'h0, dp},          32'h0);
    checkOutput("f1_count",    {24'h0, frame_count}, 32'd1);
    checkOutput("f1_fv_pulses", 32'(fvPulses - fvBase), 32'd1);

    // Frame 2: blank digit 3, dp on digit 0, ghosts between digits
    frame2Nibs = '{4'h0, 4'hA, 4'hB, 4'h0, 4'hC, 4'hD, 4'hE, 4'hF};
    fvBase = fvPulses;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) applyStimulus(selFor(3), 8'hFF, 10);
      else scanDigit(k, frame2Nibs[k], (k == 0), 10);
      applyStimulus(8'hFC, 8'hFF, 2);
      applyStimulus(selFor(6), 8'h00, 2);
    end
    applyStimulus(8'hFF, 8'hFF, 2);
    checkOutput("f2_digits",   digits,               32'hFEDC0BA0);
    checkOutput("f2_blank",    {24'h0, blank},       32'h08);
    checkOutput("f2_dp",       {24'h0, dp},          32'h01);
    checkOutput("f2_count",    {24'h0, frame_count}, 32'd2);
    checkOutput("f2_fv_pulses", 32'(fvPulses - fvBase), 32'd1);
    checkOutput("f2_no_err_oh", {31'h0, err_onehot}, 32'h0);
    checkOutput("f2_no_err_gl", {31'h0, err_glyph},  32'h0);

    // Stable two-hot select raises the sticky flag; clear drops it
    applyStimulus(8'hFC, 8'hFF, 5);
    checkOutput("oh_set",   {31'h0, err_onehot}, 32'h1);
    applyStimulus(8'hFF, 8'hFF, 2);
    pulseClear();
    checkOutput("oh_clear", {31'h0, err_onehot}, 32'h0);

    // Clear coinciding with a fresh detection: detection wins
    applyStimulus(8'hFC, 8'hFF, 3);
    err_clr = 1'b1;
    applyStimulus(8'hFC, 8'hFF, 1);
    err_clr = 1'b0;
    checkOutput("oh_wins_clr", {31'h0, err_onehot}, 32'h1);
    applyStimulus(8'hFF, 8'hFF, 2);
    pulseClear();
    checkOutput("oh_clear2", {31'h0, err_onehot}, 32'h0);

    // Frame 3: digit 2 rewritten, bad glyph 2A on digit 5
    fvBase = fvPulses;
    scanDigit(0, 4'h0, 1'b0, 10);
    scanDigit(1, 4'h1, 1'b0, 10);
    scanDigit(2, 4'h9, 1'b0, 10);
    scanDigit(3, 4'h3, 1'b0, 10);
    scanDigit(2, 4'h2, 1'b0, 10);
    scanDigit(4, 4'h4, 1'b0, 10);
    applyStimulus(selFor(5), 8'hD5, 10);
    checkOutput("gl_set", {31'h0, err_glyph}, 32'h1);
    scanDigit(6, 4'h6, 1'b0, 10);
    scanDigit(7, 4'h7, 1'b0, 10);
    checkOutput("f3_digits",   digits,               32'h76043210);
    checkOutput("f3_blank",    {24'h0, blank},       32'h0);
    checkOutput("f3_count",    {24'h0, frame_count}, 32'd3);
    checkOutput("f3_fv_pulses", 32'(fvPulses - fvBase), 32'd1);
    pulseClear();
    checkOutput("gl_clear", {31'h0, err_glyph}, 32'h0);

    // Stall: rises exactly TIMEOUT cycles after the last capture edge
    scanDigit(0, 4'h0, 1'b0, 4);
    applyStimulus(8'hFF, 8'hFF, TIMEOUT - 1);
    checkOutput("stall_before", {31'h0, stalled}, 32'h0);
    applyStimulus(8'hFF, 8'hFF, 1);
    checkOutput("stall_at",     {31'h0, stalled}, 32'h1);
    applyStimulus(8'hFF, 8'hFF, 10);
    checkOutput("stall_held",   {31'h0, stalled}, 32'h1);
    scanDigit(1, 4'h1, 1'b0, 3);
    checkOutput("stall_presettle", {31'h0, stalled}, 32'h1);
    scanDigit(1, 4'h1, 1'b0, 1);
    checkOutput("stall_cleared",   {31'h0, stalled}, 32'h0);

    // Reset mid-frame discards partial progress
    for (int k = 0; k < 5; k++) scanDigit(k, 4'(k), 1'b0, 10);
    #2 sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    checkOutput("mid_rst_count", {24'h0, frame_count}, 32'd0);
    sys_rst_n = 1'b1;
    fvBase = fvPulses;
    for (int k = 0; k < 7; k++) scanDigit(k, 4'(7 - k), 1'b0, 10);
    checkOutput("post_rst_7_fv",    32'(fvPulses - fvBase), 32'd0);
    checkOutput("post_rst_7_count", {24'h0, frame_count}, 32'd0);
    scanDigit(7, 4'h0, 1'b0, 10);
    checkOutput("post_rst_8_fv",     32'(fvPulses - fvBase), 32'd1);
    checkOutput("post_rst_8_count",  {24'h0, frame_count}, 32'd1);
    checkOutput("post_rst_8_digits", digits, 32'h01234567);
    applyStimulus(8'hFF, 8'hFF, 2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
